pc_unit_ras: RTL and testbench
==============================

Name: pc_unit_ras

Overview:
Parametrised program-counter unit, the successor to the single-register PC. It keeps the current PC and computes the next PC from five operations: sequential, absolute jump, relative branch, call and return. Call and return use an internal return-address stack (RAS). The multi-cycle controller drives it, one op per pc_write strobe; pc_out feeds instruction-memory addressing.

Parameters:
PC_W, 16, PC / target / offset width in bits
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)
RESET_VEC, 0, PC value after reset
INC, 1, sequential increment (word-addressed memory)
EXC_VEC, 16'h0008, exception entry address (used only with PC_EXC_EN)

Ports:
clk  in  1  rising-edge clock; all state updates on posedge clk
proc_rst  in  1  reset; asynchronous, active-high
pc_write  in  1  update strobe; op executes on a clk edge only when high
pc_op  in  3  000 SEQ, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET, others reserved
target  in  PC_W  absolute address for JUMP/CALL
offset  in  PC_W  two's-complement displacement for BRANCH
pc_out  out  PC_W  current PC (registered)
ras_empty  out  1  stack holds 0 entries
ras_full  out  1  stack holds RAS_DEPTH entries
ras_ovf  out  1  sticky: CALL issued while full
ras_unf  out  1  sticky: RET issued while empty

Behaviour:
- Reset (async, proc_rst=1):
  - pc_out=RESET_VEC
  - RAS count=0, top pointer=0, ras_empty=1, ras_full=0
  - ras_ovf=0, ras_unf=0
  - stack contents don't-care
  - Reset asserted mid-sequence aborts any op that edge; no partial push or pop.
- pc_write=0: PC, stack and flags hold. Ops are single-cycle; pc_out shows the new value one clk after the edge.
- SEQ: pc <= pc + INC, mod 2^PC_W (0xFFFF+1 -> 0x0000).
- JUMP: pc <= target.
- BRANCH: pc <= pc + offset, mod 2^PC_W (offset 0xFFFE = -2).
- CALL: push (pc + INC) onto RAS; pc <= target.
  - Full: overwrite the oldest entry (circular buffer), count stays RAS_DEPTH, set ras_ovf.
- RET with count>0: pc <= top entry; pop (count-1).
- RET with count=0: pc <= pc + INC; stack unchanged; set ras_unf.
- Reserved op codes: PC and stack hold. Treated as NOP, no flag.
- Stack storage: RAS_DEPTH x PC_W registers, top pointer log2(RAS_DEPTH) bits wrapping modulo depth; count 0..RAS_DEPTH.
- ras_empty and ras_full decode from the registered count (no combinational path from inputs).
- ras_ovf and ras_unf clear only on reset.
- No internal debug $display.

Optional Feature:
Macro PC_EXC_EN.
- Defined, adds ports:
  - exc_req in 1
  - eret in 1
  - epc out PC_W (reset 0)
- Priority on a clk edge: exc_req > eret > pc_write op.
- exc_req=1: epc <= pc_out; pc <= EXC_VEC; RAS untouched; pc_op ignored that edge.
- eret=1 (exc_req=0): pc <= epc.
- Both apply regardless of pc_write.
- Undefined: ports and epc register absent; behaviour exactly as above.

Test Plan:
1. Reset, then 3x SEQ -> pc_out 0,1,2,3. Assert proc_rst between edges -> pc_out=0 immediately, no clk needed.
2. pc=0x0010, BRANCH offset=0xFFFE -> 0x000E. pc=0xFFFF, SEQ -> 0x0000. pc_write=0 for 2 clks -> pc holds.
3. pc=0x0005, CALL target=0x0100 -> pc 0x0100, ras_empty=0. RET -> pc 0x0006, ras_empty=1.
4. RAS_DEPTH=4: 5 nested CALLs from pcs 0x10,0x20,0x30,0x40,0x50 -> ras_full=1, ras_ovf=1. 4 RETs -> 0x51,0x41,0x31,0x21. 5th RET -> pc+1, ras_unf=1.
5. pc_op=3'b111 with pc_write=1 -> pc and flags unchanged. Reset -> ras_ovf and ras_unf clear.
6. (PC_EXC_EN) pc=0x0042, exc_req with CALL pending -> pc 0x0008, epc 0x0042, RAS count unchanged. eret -> pc 0x0042.

Source files
------------

// File: rtl/pc_unit_ras.sv
// Program-counter unit with a circular return-address stack for CALL/RET.
// Optional exception entry/return (exc_req, eret, epc) is enabled by defining PC_EXC_EN.
module pc_unit_ras #(
  parameter int              PC_W      = 16,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              INC       = 1,
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(8)
) (
  input  logic            clk,
  input  logic            proc_rst,
  input  logic            pc_write,
  input  logic [2:0]      pc_op,
  input  logic [PC_W-1:0] target,
  input  logic [PC_W-1:0] offset,
`ifdef PC_EXC_EN
  input  logic            exc_req,
  input  logic            eret,
  output logic [PC_W-1:0] epc,
`endif
  output logic [PC_W-1:0] pc_out,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_ovf,
  output logic            ras_unf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic [2:0] {
    OP_SEQ    = 3'b000,
    OP_JUMP   = 3'b001,
    OP_BRANCH = 3'b010,
    OP_CALL   = 3'b011,
    OP_RET    = 3'b100
  } pc_op_e;

  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_next;
  logic [PC_W-1:0]  pc_seq;
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] ras_ptr_prev;
  logic [CNT_W-1:0] ras_cnt;
  logic             push;
  logic             pop;
  logic             set_ovf;
  logic             set_unf;
  logic             ovf_q;
  logic             unf_q;
`ifdef PC_EXC_EN
  logic [PC_W-1:0]  epc_q;
  logic             epc_load;
`endif

  // ras_ptr is the next free slot; when full it also holds the oldest entry,
  // so a push while full naturally overwrites the oldest return address.
  assign pc_seq       = pc_q + PC_W'(INC);
  assign ras_ptr_prev = ras_ptr - PTR_W'(1);
  assign ras_empty    = (ras_cnt == '0);
  assign ras_full     = (ras_cnt == CNT_W'(RAS_DEPTH));
  assign pc_out       = pc_q;
  assign ras_ovf      = ovf_q;
  assign ras_unf      = unf_q;

  always_comb begin
    pc_next = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
`ifdef PC_EXC_EN
    epc_load = 1'b0;
`endif
    if (pc_write) begin
      case (pc_op_e'(pc_op))
        OP_SEQ:    pc_next = pc_seq;
        OP_JUMP:   pc_next = target;
        OP_BRANCH: pc_next = pc_q + offset;
        OP_CALL: begin
          pc_next = target;
          push    = 1'b1;
          set_ovf = ras_full;
        end
        OP_RET: begin
          if (ras_empty) begin
            pc_next = pc_seq;
            set_unf = 1'b1;
          end else begin
            pc_next = ras_mem[ras_ptr_prev];
            pop     = 1'b1;
          end
        end
        default: pc_next = pc_q;
      endcase
    end
`ifdef PC_EXC_EN
    // Exception entry beats exception return, which beats any pending op.
    if (exc_req) begin
      pc_next  = EXC_VEC;
      epc_load = 1'b1;
      push     = 1'b0;
      pop      = 1'b0;
      set_ovf  = 1'b0;
      set_unf  = 1'b0;
    end else if (eret) begin
      pc_next = epc_q;
      push    = 1'b0;
      pop     = 1'b0;
      set_ovf = 1'b0;
      set_unf = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge proc_rst) begin
    if (proc_rst) begin
      pc_q    <= RESET_VEC;
      ras_ptr <= '0;
      ras_cnt <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q <= pc_next;
      if (push) begin
        ras_ptr <= ras_ptr + PTR_W'(1);
        if (!ras_full) ras_cnt <= ras_cnt + CNT_W'(1);
      end else if (pop) begin
        ras_ptr <= ras_ptr_prev;
        ras_cnt <= ras_cnt - CNT_W'(1);
      end
      if (set_ovf) ovf_q <= 1'b1;
      if (set_unf) unf_q <= 1'b1;
    end
  end

  // Storage has no reset; gating with proc_rst stops a push on an aborted edge.
  always_ff @(posedge clk) begin
    if (push && !proc_rst) ras_mem[ras_ptr] <= pc_seq;
  end

`ifdef PC_EXC_EN
  always_ff @(posedge clk or posedge proc_rst) begin
    if (proc_rst) epc_q <= '0;
    else if (epc_load) epc_q <= pc_q;
  end

  assign epc = epc_q;
`endif

endmodule

// File: tb/tb_pc_unit_ras.sv
// Scoreboard bench for pc_unit_ras: a queue-based stack model predicts each op's outcome.
module tb_pc_unit_ras;

  logic        clk = 1'b0;
  logic        proc_rst = 1'b0;
  logic        pc_write = 1'b0;
  logic [2:0]  pc_op = 3'b000;
  logic [15:0] target = '0;
  logic [15:0] offset = '0;
  logic [15:0] pc_out;
  logic        ras_empty, ras_full, ras_ovf, ras_unf;
`ifdef PC_EXC_EN
  logic        exc_req = 1'b0;
  logic        eret = 1'b0;
  logic [15:0] epc;
`endif

  typedef struct packed {
    logic [15:0] pc;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m_stack[$];
  logic [15:0] m_pc;
  logic        m_ovf, m_unf;
  int          tests_run = 0;
  int          tests_failed = 0;

  pc_unit_ras dut (
    .clk(clk), .proc_rst(proc_rst), .pc_write(pc_write), .pc_op(pc_op),
    .target(target), .offset(offset),
`ifdef PC_EXC_EN
    .exc_req(exc_req), .eret(eret), .epc(epc),
`endif
    .pc_out(pc_out), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not finish, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, actual, expected);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.pc    = m_pc;
    e.empty = (m_stack.size() == 0);
    e.full  = (m_stack.size() == 4);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  task automatic modelReset();
    m_pc = 16'h0000;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic modelOp(input logic [2:0] op, input logic [15:0] tgt, input logic [15:0] off);
    case (op)
      3'b000: m_pc = m_pc + 16'd1;
      3'b001: m_pc = tgt;
      3'b010: m_pc = m_pc + off;
      3'b011: begin
        m_stack.push_back(m_pc + 16'd1);
        if (m_stack.size() > 4) begin
          void'(m_stack.pop_front());
          m_ovf = 1'b1;
        end
        m_pc = tgt;
      end
      3'b100: begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin
          m_pc  = m_pc + 16'd1;
          m_unf = 1'b1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compareHead(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checkOutput({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    checkOutput({tag, "_pc"}, {16'h0, pc_out}, {16'h0, e.pc});
    checkOutput({tag, "_empty"}, {31'h0, ras_empty}, {31'h0, e.empty});
    checkOutput({tag, "_full"}, {31'h0, ras_full}, {31'h0, e.full});
    checkOutput({tag, "_ovf"}, {31'h0, ras_ovf}, {31'h0, e.ovf});
    checkOutput({tag, "_unf"}, {31'h0, ras_unf}, {31'h0, e.unf});
  endtask

  task automatic applyStimulus(input string tag, input logic wr, input logic [2:0] op,
                               input logic [15:0] tgt, input logic [15:0] off);
    @(negedge clk);
    pc_write = wr;
    pc_op    = op;
    target   = tgt;
    offset   = off;
    if (wr) modelOp(op, tgt, off);
    sb_q.push_back(snapshot());
    @(posedge clk);
    #1;
    pc_write = 1'b0;
    compareHead(tag);
  endtask

  // Reset asserted between edges must take effect without a clock.
  task automatic applyReset(input string tag);
    @(negedge clk);
    #2;
    proc_rst = 1'b1;
    modelReset();
    sb_q.push_back(snapshot());
    #1;
    compareHead(tag);
    @(negedge clk);
    proc_rst = 1'b0;
  endtask

  initial begin
    modelReset();
    proc_rst = 1'b1;
    #12;
    proc_rst = 1'b0;

    // Sequential stepping from the reset vector, then a mid-cycle reset
    applyReset("rst0");
    applyStimulus("seq1", 1'b1, 3'b000, 16'h0, 16'h0);
    applyStimulus("seq2", 1'b1, 3'b000, 16'h0, 16'h0);
    applyStimulus("seq3", 1'b1, 3'b000, 16'h0, 16'h0);
    applyReset("rst_mid");

    // A write pending while reset spans the edge must be discarded
    @(negedge clk);
    pc_write = 1'b1;
    pc_op    = 3'b011;
    target   = 16'h0200;
    proc_rst = 1'b1;
    @(negedge clk);
    proc_rst = 1'b0;
    pc_write = 1'b0;
    sb_q.push_back(snapshot());
    #1;
    compareHead("rst_abort");

    // Branch backwards, wrap on SEQ, hold with pc_write low
    applyStimulus("jmp10", 1'b1, 3'b001, 16'h0010, 16'h0);
    applyStimulus("br_m2", 1'b1, 3'b010, 16'h0, 16'hFFFE);
    applyStimulus("br_p5", 1'b1, 3'b010, 16'h0, 16'h0005);
    applyStimulus("jmpff", 1'b1, 3'b001, 16'hFFFF, 16'h0);
    applyStimulus("seqwrap", 1'b1, 3'b000, 16'h0, 16'h0);
    applyStimulus("hold1", 1'b0, 3'b001, 16'h1234, 16'h0);
    applyStimulus("hold2", 1'b0, 3'b011, 16'h5678, 16'h0);

    // Single call/return pair
    applyStimulus("jmp05", 1'b1, 3'b001, 16'h0005, 16'h0);
    applyStimulus("call1", 1'b1, 3'b011, 16'h0100, 16'h0);
    applyStimulus("ret1", 1'b1, 3'b100, 16'h0, 16'h0);

    // Nested calls past the stack depth, then drain and underflow
    for (int i = 1; i <= 5; i++) begin
      applyStimulus($sformatf("jmpn%0d", i), 1'b1, 3'b001, 16'(i * 16), 16'h0);
      applyStimulus($sformatf("calln%0d", i), 1'b1, 3'b011, 16'h0300 + 16'(i), 16'h0);
    end
    for (int i = 1; i <= 5; i++)
      applyStimulus($sformatf("retn%0d", i), 1'b1, 3'b100, 16'h0, 16'h0);

    // Reserved op code is a no-op; reset clears sticky flags
    applyStimulus("rsv7", 1'b1, 3'b111, 16'hAAAA, 16'h5555);
    applyStimulus("rsv5", 1'b1, 3'b101, 16'hAAAA, 16'h5555);
    applyReset("rst_flags");

`ifdef PC_EXC_EN
    applyStimulus("jmp42", 1'b1, 3'b001, 16'h0042, 16'h0);
    applyStimulus("call_pre", 1'b1, 3'b011, 16'h0042, 16'h0);
    @(negedge clk);
    exc_req  = 1'b1;
    pc_write = 1'b1;
    pc_op    = 3'b011;
    target   = 16'h0999;
    sb_q.push_back('{pc: 16'h0008, empty: 1'b0, full: 1'b0, ovf: 1'b0, unf: 1'b0});
    @(posedge clk);
    #1;
    exc_req  = 1'b0;
    pc_write = 1'b0;
    compareHead("exc");
    checkOutput("exc_epc", {16'h0, epc}, 32'h0042);
    @(negedge clk);
    eret = 1'b1;
    sb_q.push_back('{pc: 16'h0042, empty: 1'b0, full: 1'b0, ovf: 1'b0, unf: 1'b0});
    @(posedge clk);
    #1;
    eret = 1'b0;
    compareHead("eret");
    m_pc = 16'h0042;
    applyStimulus("ret_after_exc", 1'b1, 3'b100, 16'h0, 16'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
